sb_serializer: RTL and testbench

SB_SERIALIZER -- requirements
Module: sb_serializer

---
 rtl/sb_serializer.sv | 162 ++++++++++++++++
 tb/tb_sb_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sb_serializer.sv
// rtl/sb_serializer.sv - sideband byte serializer: byte FIFO feeding a frame-aligned LSB-first shift register
//
// Optional feature macro: SB_SER_UNDERRUN_CNT_EN
//   When defined, adds output underrun_cnt: a saturating count of ACTIVE->IDLE
//   transitions that happen while enable is high (the FIFO ran dry mid-stream).
//
// Frames are WIDTH clocks long and locked to reset release by a free-running
// counter, so a free-running downstream deserializer stays aligned no matter
// when data shows up. Idle frames carry IDLE_BYTE.

module sb_serializer #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] IDLE_BYTE = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             busy
`ifdef SB_SER_UNDERRUN_CNT_EN
  ,
  output logic [7:0]       underrun_cnt
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  // Frame position and boundary detection
  logic [CW-1:0] bit_cnt;
  logic          boundary;

  // Byte FIFO
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Transmit path
  logic [WIDTH-1:0] shift_reg;
  logic             load_data;
  state_t           state_q;
  state_t           state_d;

  assign boundary = (bit_cnt == LAST_BIT);
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

  // Pop decision looks only at FIFO state before this edge, so a byte pushed
  // on a boundary edge waits for the following boundary (no bypass path).
  assign load_data = boundary && enable && !empty;
  assign pop       = load_data;
  assign push      = data_valid && !full;

  assign data_ready = !full;
  assign serial_out = shift_reg[0];
  assign busy       = (state_q == S_ACTIVE) || !empty;

  // Free-running frame counter, independent of enable and FIFO state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (boundary) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide on a boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Shift register: reload at each boundary, otherwise shift out LSB first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= IDLE_BYTE;
    end else if (boundary) begin
      shift_reg <= load_data ? mem[rd_ptr] : IDLE_BYTE;
    end else begin
      shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: only boundaries move it; data load -> ACTIVE, idle load -> IDLE
  always_comb begin
    state_d = state_q;
    if (boundary) begin
      if (load_data) begin
        state_d = S_ACTIVE;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

`ifdef SB_SER_UNDERRUN_CNT_EN
  logic underrun_evt;

  // An underrun is the stream dropping to idle although transmit was permitted
  assign underrun_evt = boundary && !load_data && enable && (state_q == S_ACTIVE);

  // Saturating underrun counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_cnt <= 8'd0;
    end else if (underrun_evt && (underrun_cnt != 8'hFF)) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sb_serializer.sv
// tb/tb_sb_serializer.sv - directed + randomized scoreboard bench for sb_serializer
module tb_sb_serializer;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] IDLE  = 8'h00;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       serial_out;
  logic       busy;
`ifdef SB_SER_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif

  int total;
  int bad;
  int cyc;

  logic [7:0] mq[$];
  logic       exp_bits[$];
  logic       m_active;
  int         m_under;

  sb_serializer #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .IDLE_BYTE(IDLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .serial_out  (serial_out),
    .busy        (busy)
`ifdef SB_SER_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] fb);
    for (int i = 0; i < WIDTH; i++) begin
      exp_bits.push_back(fb[i]);
    end
  endtask

  // Compare this cycle's outputs, advance the model across the coming edge, then step to the next cycle.
  task automatic step();
    logic       exp_bit;
    logic [7:0] fb;
    logic       pushed;
    if (exp_bits.size() == 0) begin
      check("scoreboard_underflow", 8'd1, 8'd0);
      exp_bit = 1'b0;
    end else begin
      exp_bit = exp_bits.pop_front();
    end
    check("serial_out", {7'd0, serial_out}, {7'd0, exp_bit});
    check("data_ready", {7'd0, data_ready}, {7'd0, mq.size() < DEPTH});
    check("busy", {7'd0, busy}, {7'd0, m_active || (mq.size() != 0)});
`ifdef SB_SER_UNDERRUN_CNT_EN
    check("underrun_cnt", underrun_cnt, 8'(m_under));
`endif
    pushed = data_valid && (mq.size() < DEPTH);
    if ((cyc % WIDTH) == WIDTH - 1) begin
      if (enable && mq.size() != 0) begin
        fb = mq.pop_front();
        m_active = 1'b1;
      end else begin
        fb = IDLE;
        if (m_active && enable && m_under < 255) m_under++;
        m_active = 1'b0;
      end
      push_frame(fb);
    end
    if (pushed) mq.push_back(data_in);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input logic dv, input logic [7:0] d, input logic en);
    data_valid = dv;
    data_in    = d;
    enable     = en;
    step();
  endtask

  task automatic idle_to(input int n, input logic en);
    while (cyc < n) go(1'b0, 8'h00, en);
  endtask

  // Assert reset now, check the asynchronous reset values, release on a falling edge.
  task automatic do_reset();
    logic [7:0] idle_v;
    idle_v     = IDLE;
    rst        = 1'b0;
    data_valid = 1'b0;
    #2;
    check("rst_serial_out", {7'd0, serial_out}, {7'd0, idle_v[0]});
    check("rst_data_ready", {7'd0, data_ready}, 8'd1);
    check("rst_busy", {7'd0, busy}, 8'd0);
`ifdef SB_SER_UNDERRUN_CNT_EN
    check("rst_underrun_cnt", underrun_cnt, 8'd0);
`endif
    mq.delete();
    exp_bits.delete();
    m_active = 1'b0;
    m_under  = 0;
    cyc      = 0;
    push_frame(idle_v);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    cyc        = 0;
    rst        = 1'b0;
    enable     = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;

    // No data: idle line for 32 cycles
    do_reset();
    idle_to(32, 1'b1);

    // Single byte A5 pushed at cycle 2, carried in frame 1, frame 2 idle
    do_reset();
    idle_to(2, 1'b1);
    go(1'b1, 8'hA5, 1'b1);
    idle_to(32, 1'b1);

    // Five back-to-back pushes: fifth dropped while full
    do_reset();
    go(1'b1, 8'h01, 1'b1);
    go(1'b1, 8'h02, 1'b1);
    go(1'b1, 8'h03, 1'b1);
    go(1'b1, 8'h04, 1'b1);
    go(1'b1, 8'h05, 1'b1);
    idle_to(48, 1'b1);

    // Enable dropped mid-frame: frame 1 completes, FIFO held, resumes later
    do_reset();
    go(1'b1, 8'hFF, 1'b1);
    go(1'b1, 8'hFF, 1'b1);
    idle_to(10, 1'b1);
    idle_to(30, 1'b0);
    idle_to(48, 1'b1);

    // Push on a boundary edge is not bypassed; reset mid-frame 3 flushes everything
    do_reset();
    idle_to(7, 1'b1);
    go(1'b1, 8'h5A, 1'b1);
    go(1'b1, 8'hFF, 1'b1);
    go(1'b1, 8'h77, 1'b1);
    idle_to(27, 1'b1);
    do_reset();
    idle_to(3, 1'b1);
    go(1'b1, 8'h3C, 1'b1);
    idle_to(24, 1'b1);

    // Randomized traffic: wraps pointers, exercises push/pop on the same edge
    do_reset();
    for (int i = 0; i < 400; i++) begin
      go(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
    end

`ifdef SB_SER_UNDERRUN_CNT_EN
    // 300 isolated bytes, each followed by an idle frame: counter saturates
    do_reset();
    for (int i = 0; i < 300; i++) begin
      go(1'b1, 8'(i + 1), 1'b1);
      idle_to(16 * (i + 1), 1'b1);
    end
    idle_to(16 * 300 + 16, 1'b1);
    check("underrun_saturated", underrun_cnt, 8'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
